// File: rtl/seven_seg_count_monitor_if.sv
// Segment inputs and decoded status of the seven-segment count monitor.
// master drives the display side; slave is the monitor itself.
interface seven_seg_count_monitor_if #(
  parameter int unsigned ERR_W = 8
);
  logic             a, b, c, d, e, f, g;
  logic             seg;
  logic [3:0]       value;
  logic             valid;
  logic             dir;
  logic             step_err;
  logic             pat_err;
  logic             stalled;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output a, b, c, d, e, f, g, seg,
    input  value, valid, dir, step_err, pat_err, stalled, err_cnt
  );

  modport slave (
    input  a, b, c, d, e, f, g, seg,
    output value, valid, dir, step_err, pat_err, stalled, err_cnt
  );
endinterface

// File: rtl/seven_seg_count_monitor.sv
// Receive-side checker for a 7-segment up/down counter display: decodes glyphs back to hex,
// tracks direction and flags illegal glyphs, non-unit steps and a stalled count.
module seven_seg_count_monitor #(
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned STALL_CYC  = 20,
  parameter int unsigned ERR_W      = 8
) (
  input logic                      clk,
  input logic                      rst,
  seven_seg_count_monitor_if.slave bus
);

  localparam int unsigned SW = $clog2(STALL_CYC + 1);
  localparam logic [SW-1:0] StallMax = SW'(STALL_CYC);

  typedef enum logic {StInit, StTrack} state_e;

  // Returns {legal, hex} for a gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    unique case (p)
      7'h3F:   decode = {1'b1, 4'h0};
      7'h06:   decode = {1'b1, 4'h1};
      7'h5B:   decode = {1'b1, 4'h2};
      7'h4F:   decode = {1'b1, 4'h3};
      7'h66:   decode = {1'b1, 4'h4};
      7'h6D:   decode = {1'b1, 4'h5};
      7'h7D:   decode = {1'b1, 4'h6};
      7'h07:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h6F:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h7C:   decode = {1'b1, 4'hB};
      7'h39:   decode = {1'b1, 4'hC};
      7'h5E:   decode = {1'b1, 4'hD};
      7'h79:   decode = {1'b1, 4'hE};
      7'h71:   decode = {1'b1, 4'hF};
      default: decode = {1'b0, 4'h0};
    endcase
  endfunction

  logic [6:0]       pat_q;
  logic             en_q;
  state_e           state_q, state_d;
  logic [3:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic             step_err_q, step_err_d;
  logic             pat_err_q, pat_err_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             legal;
  logic [3:0]       dec_val;

  // Stage 1: capture raw pattern, normalised to active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      en_q  <= 1'b0;
    end else begin
      pat_q <= {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} ^ {7{ACTIVE_LOW}};
      en_q  <= bus.seg;
    end
  end

  assign {legal, dec_val} = decode(pat_q);

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    valid_d    = valid_q;
    dir_d      = dir_q;
    stall_d    = stall_q;
    step_err_d = 1'b0;
    pat_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (en_q) begin
      if (!legal) begin
        pat_err_d = 1'b1;
      end else if (state_q == StInit) begin
        value_d = dec_val;
        valid_d = 1'b1;
        state_d = StTrack;
      end else if (dec_val == value_q) begin
        if (stall_q != StallMax) stall_d = stall_q + 1'b1;
      end else begin
        value_d = dec_val;
        stall_d = '0;
        if (dec_val == 4'(value_q + 4'd1))      dir_d = 1'b1;
        else if (dec_val == 4'(value_q - 4'd1)) dir_d = 1'b0;
        else                                    step_err_d = 1'b1;
      end
    end
    if ((step_err_d || pat_err_d) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Stage 2: decoded state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInit;
      value_q    <= '0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b1;
      stall_q    <= '0;
      step_err_q <= 1'b0;
      pat_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      stall_q    <= stall_d;
      step_err_q <= step_err_d;
      pat_err_q  <= pat_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.valid    = valid_q;
  assign bus.dir      = dir_q;
  assign bus.step_err = step_err_q;
  assign bus.pat_err  = pat_err_q;
  assign bus.stalled  = (stall_q == StallMax);
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_seven_seg_count_monitor.sv
// Directed bench for seven_seg_count_monitor: active-high and active-low instances.
module tb_seven_seg_count_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seven_seg_count_monitor_if #(.ERR_W(8)) bus   ();
  seven_seg_count_monitor_if #(.ERR_W(8)) bus_l ();

  seven_seg_count_monitor #(.ACTIVE_LOW(1'b0), .STALL_CYC(20), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seven_seg_count_monitor #(.ACTIVE_LOW(1'b1), .STALL_CYC(20), .ERR_W(8)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  task automatic drive(input logic [6:0] p, input logic s);
    {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = p;
    bus.seg = s;
  endtask

  task automatic drive_l(input logic [6:0] p, input logic s);
    {bus_l.g, bus_l.f, bus_l.e, bus_l.d, bus_l.c, bus_l.b, bus_l.a} = p;
    bus_l.seg = s;
  endtask

  // One enabled sample, then blank; returns #1 after the edge that shows its decode.
  task automatic sample(input logic [6:0] p);
    drive(p, 1'b1);
    @(posedge clk); #1;
    bus.seg = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sample_l(input logic [6:0] p);
    drive_l(p, 1'b1);
    @(posedge clk); #1;
    bus_l.seg = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(7'h00, 1'b0);
    drive_l(7'h7F, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.value, bus.valid, bus.dir, bus.step_err, bus.pat_err, bus.stalled} !== 9'b0000_0_1_0_0_0
        || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got value=%0h valid=%0b dir=%0b se=%0b pe=%0b st=%0b ec=%0d",
               bus.value, bus.valid, bus.dir, bus.step_err, bus.pat_err, bus.stalled,
               bus.err_cnt);
    end
  endtask

  task automatic test_count_up();
    logic [6:0] pats [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(pats[i]);
      checks++;
      if (bus.value !== 4'(i) || bus.valid !== 1'b1 || bus.dir !== 1'b1 ||
          bus.step_err !== 1'b0 || bus.pat_err !== 1'b0) begin
        errors++;
        $display("FAIL count_up[%0d] got value=%0h valid=%0b dir=%0b se=%0b pe=%0b want %0h 1 1 0 0",
                 i, bus.value, bus.valid, bus.dir, bus.step_err, bus.pat_err, i);
      end
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL count_up_errcnt got %0d want 0", bus.err_cnt);
    end
  endtask

  task automatic test_down_wrap();
    logic [6:0] pats [4] = '{7'h06, 7'h3F, 7'h71, 7'h79};
    logic [3:0] vals [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(pats[i]);
      checks++;
      if (bus.value !== vals[i] || bus.step_err !== 1'b0) begin
        errors++;
        $display("FAIL down_wrap[%0d] got value=%0h se=%0b want %0h 0",
                 i, bus.value, bus.step_err, vals[i]);
      end
      if (i >= 1) begin
        checks++;
        if (bus.dir !== 1'b0) begin
          errors++;
          $display("FAIL down_wrap_dir[%0d] got %0b want 0", i, bus.dir);
        end
      end
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL down_wrap_errcnt got %0d want 0", bus.err_cnt);
    end
  endtask

  task automatic test_jump();
    do_reset();
    sample(7'h66);
    sample(7'h4F);
    sample(7'h7D);
    checks++;
    if (bus.step_err !== 1'b1 || bus.value !== 4'h6 || bus.err_cnt !== 8'd1 || bus.dir !== 1'b0)
    begin
      errors++;
      $display("FAIL jump got se=%0b value=%0h ec=%0d dir=%0b want 1 6 1 0",
               bus.step_err, bus.value, bus.err_cnt, bus.dir);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.step_err !== 1'b0) begin
      errors++;
      $display("FAIL jump_pulse_width got se=%0b want 0", bus.step_err);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    sample(7'h00);
    checks++;
    if (bus.pat_err !== 1'b1 || bus.valid !== 1'b0 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL illegal_init got pe=%0b valid=%0b ec=%0d want 1 0 1",
               bus.pat_err, bus.valid, bus.err_cnt);
    end
    sample(7'h3F);
    sample(7'h00);
    checks++;
    if (bus.pat_err !== 1'b1 || bus.step_err !== 1'b0 || bus.value !== 4'h0 ||
        bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL illegal_blank got pe=%0b se=%0b value=%0h ec=%0d want 1 0 0 2",
               bus.pat_err, bus.step_err, bus.value, bus.err_cnt);
    end
    sample(7'h7E);
    checks++;
    if (bus.pat_err !== 1'b1 || bus.value !== 4'h0 || bus.err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL illegal_7e got pe=%0b value=%0h ec=%0d want 1 0 3",
               bus.pat_err, bus.value, bus.err_cnt);
    end
    drive(7'h7E, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.pat_err !== 1'b0 || bus.err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL illegal_seg_off got pe=%0b ec=%0d want 0 3", bus.pat_err, bus.err_cnt);
    end
    for (int i = 0; i < 256; i++) sample(7'h00);
    checks++;
    if (bus.err_cnt !== 8'hFF || bus.value !== 4'h0) begin
      errors++;
      $display("FAIL errcnt_saturate got ec=%0d value=%0h want 255 0", bus.err_cnt, bus.value);
    end
  endtask

  task automatic test_stall();
    do_reset();
    sample(7'h6D);
    sample(7'h66);
    for (int i = 1; i <= 21; i++) begin
      sample(7'h66);
      if (i == 19 || i == 20 || i == 21) begin
        checks++;
        if (bus.stalled !== (i >= 20)) begin
          errors++;
          $display("FAIL stall_repeat[%0d] got %0b want %0b", i, bus.stalled, (i >= 20));
        end
      end
    end
    sample(7'h6D);
    checks++;
    if (bus.stalled !== 1'b0 || bus.dir !== 1'b1 || bus.value !== 4'h5 || bus.step_err !== 1'b0)
    begin
      errors++;
      $display("FAIL stall_release got st=%0b dir=%0b value=%0h se=%0b want 0 1 5 0",
               bus.stalled, bus.dir, bus.value, bus.step_err);
    end
  endtask

  task automatic test_active_low();
    do_reset();
    sample_l(~7'h3F);
    checks++;
    if (bus_l.value !== 4'h0 || bus_l.valid !== 1'b1 || bus_l.pat_err !== 1'b0) begin
      errors++;
      $display("FAIL active_low_0 got value=%0h valid=%0b pe=%0b want 0 1 0",
               bus_l.value, bus_l.valid, bus_l.pat_err);
    end
    sample_l(~7'h06);
    checks++;
    if (bus_l.value !== 4'h1 || bus_l.dir !== 1'b1 || bus_l.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL active_low_1 got value=%0h dir=%0b ec=%0d want 1 1 0",
               bus_l.value, bus_l.dir, bus_l.err_cnt);
    end
    // Reset asserted between edges while a sample is in flight.
    drive_l(~7'h5B, 1'b1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_l.value !== 4'h0 || bus_l.valid !== 1'b0 || bus_l.dir !== 1'b1 ||
        bus_l.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got value=%0h valid=%0b dir=%0b ec=%0d want 0 0 1 0",
               bus_l.value, bus_l.valid, bus_l.dir, bus_l.err_cnt);
    end
    rst = 1'b0;
    bus_l.seg = 1'b0;
    sample_l(~7'h4F);
    checks++;
    if (bus_l.value !== 4'h3 || bus_l.valid !== 1'b1 || bus_l.step_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_init got value=%0h valid=%0b se=%0b want 3 1 0",
               bus_l.value, bus_l.valid, bus_l.step_err);
    end
  endtask

  initial begin
    drive(7'h00, 1'b0);
    drive_l(7'h7F, 1'b0);
    #1;
    test_reset();
    test_count_up();
    test_down_wrap();
    test_jump();
    test_illegal();
    test_stall();
    test_active_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
